// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen geometry, paddle constants and plot FSM states
package pong_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int XW       = 9;
    localparam int YW       = 8;
    localparam int X_LEFT   = 0;
    localparam int X_RIGHT  = 310;
    localparam int Y_TOP    = 0;
    localparam int Y_BOTTOM = 230;
    localparam int STEP     = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ERASE_REQ = 2'd1,
        UPDATE    = 2'd2,
        DRAW_REQ  = 2'd3
    } plot_state_t;

endpackage

// File: rtl/upstate_ctrl_if.sv
// rtl/upstate_ctrl_if.sv - paddle plot request/acknowledge bundle towards the plot engine
interface upstate_ctrl_if;
    import pong_pkg::*;

    logic          plot_req;
    logic          plot_ack;
    logic          plot_erase;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    modport master (output plot_req, output plot_erase, output x, output y, input plot_ack);
    modport slave  (input plot_req, input plot_erase, input x, input y, output plot_ack);

endinterface

// File: rtl/upstate_ctrl.sv
// rtl/upstate_ctrl.sv - moves a paddle up one step per request, erasing then redrawing it
module upstate_ctrl
    import pong_pkg::*;
#(
    parameter int STEP_PX  = STEP,
    parameter int Y_TOP_PX = Y_TOP,
    parameter int Y_RESET  = 110,
    parameter int X_R      = X_RIGHT,
    parameter int X_L      = X_LEFT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              player,
    input  logic              move_up,
    input  logic [YW-1:0]     y_in,
    input  logic              load,
    upstate_ctrl_if.master    pif,
    output logic              at_top,
    output logic              busy
);

    localparam logic [XW-1:0] X_R_V   = XW'(X_R);
    localparam logic [XW-1:0] X_L_V   = XW'(X_L);
    localparam logic [YW-1:0] Y_RST_V = YW'(Y_RESET);
    localparam logic [YW-1:0] Y_TOP_V = YW'(Y_TOP_PX);
    localparam logic [8:0]    STEP9   = 9'(STEP_PX);
    localparam logic [8:0]    LIMIT9  = 9'(Y_TOP_PX + STEP_PX);

    plot_state_t   state;
    logic [YW-1:0] y_q;
    logic          req_q;
    logic          erase_q;
    logic          pending;
    logic [8:0]    y_ext;

    assign y_ext          = {1'b0, y_q};
    assign pif.x          = player ? X_R_V : X_L_V;
    assign pif.y          = y_q;
    assign pif.plot_req   = req_q;
    assign pif.plot_erase = erase_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            y_q     <= Y_RST_V;
            req_q   <= 1'b0;
            erase_q <= 1'b0;
            busy    <= 1'b0;
            pending <= 1'b0;
            at_top  <= 1'b0;
        end else begin
            // Deliberately lags y by one cycle so it reflects the committed position.
            at_top <= (y_q == Y_TOP_V);
            case (state)
                IDLE: begin
                    if (load) begin
                        y_q <= y_in;
                    end else if (move_up || pending) begin
                        pending <= 1'b0;
                        if (!at_top) begin
                            state   <= ERASE_REQ;
                            req_q   <= 1'b1;
                            erase_q <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                ERASE_REQ: begin
                    if (move_up) pending <= 1'b1;
                    if (pif.plot_ack) begin
                        state   <= UPDATE;
                        req_q   <= 1'b0;
                        erase_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (move_up) pending <= 1'b1;
                    // Widened compare keeps the step from wrapping past the top.
                    y_q   <= (y_ext >= LIMIT9) ? YW'(y_ext - STEP9) : Y_TOP_V;
                    state <= DRAW_REQ;
                    req_q <= 1'b1;
                end
                DRAW_REQ: begin
                    if (move_up) pending <= 1'b1;
                    if (pif.plot_ack) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
